uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver with a held output word.
//
// The serial line is synchronized, then each bit is decided by a 3-sample
// majority vote around the bit centre. A completed frame is held in an output
// register until the consumer accepts it. If a frame completes while an
// unaccepted word is still held, the new frame is dropped and o_Overrun
// pulses for one cycle.
//
// Optional feature: define UART_RX_PARITY_EN to receive one parity bit after
// the data bits and report o_Parity_Err. Without it, no parity bit is
// expected on the line and o_Parity_Err is tied to 0.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit (8..4095)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity (parity builds only)
//
// Ports
//   i_Clock       sole clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_Serial   asynchronous serial input, idle high
//   i_Rx_Ready    consumer accepts the held word
//   o_Rx_DV       held word valid
//   o_Rx_Byte     held data word, LSB received first
//   o_Frame_Err   held word had a stop bit sampled low (qualified by o_Rx_DV)
//   o_Parity_Err  held word failed parity (qualified by o_Rx_DV)
//   o_Overrun     one-cycle pulse when a completed frame is dropped
//   o_Busy        receiver is not idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge
// START  | validating the start bit (glitch rejection)
// DATA   | shifting in data bits, LSB first
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling stop bits, frame completes on the last one
// BREAK  | stop bit was low; wait for the line to return high

module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic                 i_Rx_Serial,
   input  logic                 i_Rx_Ready,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Frame_Err,
   output logic                 o_Parity_Err,
   output logic                 o_Overrun,
   output logic                 o_Busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int H     = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] C_SMP0   = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] C_SMP1   = CNT_W'(H);
   localparam logic [CNT_W-1:0] C_DECIDE = CNT_W'(H + 1);
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [3:0] C_LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] C_LAST_STOP = 4'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 4095) begin : g_bad_cpb
      $error("uart_rx_cfg: CLKS_PER_BIT out of range");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_cfg: DATA_BITS out of range");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_rx_meta;
   logic                  r_rx_sync;
   logic [CNT_W-1:0]      r_clk_cnt;
   logic [3:0]            r_bit_cnt;
   logic                  r_s0;
   logic                  r_s1;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_ferr_acc;
   logic                  r_dv;
   logic [DATA_BITS-1:0]  r_byte;
   logic                  r_ferr;
   logic                  r_ovr;

   logic                  w_in_bit;
   logic                  w_tick;
   logic                  w_bit;
   logic                  w_done;
   logic                  w_done_ferr;

   // two-flop synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= i_Rx_Serial;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_in_bit = (r_state != S_IDLE) && (r_state != S_BREAK);
   assign w_tick   = w_in_bit && (r_clk_cnt == C_DECIDE);
   // third vote is the live synchronized sample at the decision count
   assign w_bit    = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
   assign w_done_ferr = r_ferr_acc | ~w_bit;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE:  if (!r_rx_sync) w_state_nxt = S_START;
         S_START: if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
         S_DATA:
            if (w_tick && (r_bit_cnt == C_LAST_DATA)) begin
`ifdef UART_RX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
         S_STOP:
            if (w_tick && (r_bit_cnt == C_LAST_STOP)) begin
               w_done      = 1'b1;
               w_state_nxt = w_done_ferr ? S_BREAK : S_IDLE;
            end
         S_BREAK: if (r_rx_sync) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The sample counter free-runs 0..CLKS_PER_BIT-1 from the start edge, so
   // every decision lands at count H+1, one bit period after the last one.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_clk_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
         r_shift    <= '0;
         r_ferr_acc <= 1'b0;
      end else begin
         if (!w_in_bit) begin
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_ferr_acc <= 1'b0;
         end else begin
            r_clk_cnt <= (r_clk_cnt == C_LAST) ? '0 : r_clk_cnt + 1'b1;
            if (r_clk_cnt == C_SMP0) r_s0 <= r_rx_sync;
            if (r_clk_cnt == C_SMP1) r_s1 <= r_rx_sync;
            if (w_tick) begin
               case (r_state)
                  S_DATA: begin
                     r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt <= (r_bit_cnt == C_LAST_DATA) ? 4'd0 : r_bit_cnt + 4'd1;
                  end
                  S_STOP: begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (!w_bit) r_ferr_acc <= 1'b1;
                  end
                  default: r_bit_cnt <= 4'd0;
               endcase
            end
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   localparam logic C_PAR_ODD = 1'(PARITY_ODD);

   logic r_perr_acc;
   logic r_perr;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_perr_acc <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_perr_acc <= 1'b0;
      end else if (w_tick && (r_state == S_PARITY)) begin
         r_perr_acc <= (^{r_shift, w_bit}) ^ C_PAR_ODD;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n)                         r_perr <= 1'b0;
      else if (w_done && (!r_dv || i_Rx_Ready)) r_perr <= r_perr_acc;
   end

   assign o_Parity_Err = r_perr;
`else
   assign o_Parity_Err = 1'b0;
`endif

   // output holding register; a completion coinciding with an accept reloads
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_dv   <= 1'b0;
         r_byte <= '0;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (w_done) begin
            if (!r_dv || i_Rx_Ready) begin
               r_dv   <= 1'b1;
               r_byte <= r_shift;
               r_ferr <= w_done_ferr;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_dv && i_Rx_Ready) begin
            r_dv <= 1'b0;
         end
      end
   end

   assign o_Rx_DV     = r_dv;
   assign o_Rx_Byte   = r_byte;
   assign o_Frame_Err = r_ferr;
   assign o_Overrun   = r_ovr;
   assign o_Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       ready;
   logic       dv;
   logic [7:0] rx_byte;
   logic       ferr;
   logic       perr;
   logic       ovr;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   int         acc_cnt = 0;
   int         ovr_cnt = 0;
   logic [7:0] last_byte = '0;
   logic       last_ferr = 1'b0;
   logic       last_perr = 1'b0;

   uart_rx_cfg #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .STOP_BITS    (1),
      .PARITY_ODD   (0)
   ) u_dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_Rx_Serial  (rx),
      .i_Rx_Ready   (ready),
      .o_Rx_DV      (dv),
      .o_Rx_Byte    (rx_byte),
      .o_Frame_Err  (ferr),
      .o_Parity_Err (perr),
      .o_Overrun    (ovr),
      .o_Busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every accepted word and every overrun pulse
   always @(negedge clk) begin
      if (rst_n && dv && ready) begin
         acc_cnt   <= acc_cnt + 1;
         last_byte <= rx_byte;
         last_ferr <= ferr;
         last_perr <= perr;
      end
      if (rst_n && ovr) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   // rst_bit >= 0 pulses reset 6 cycles into that data bit
   task automatic send_frame(input logic [7:0] data, input logic stop_val,
                             input int rst_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_bit) begin
            rx = data[i];
            tick(6);
            rst_n = 1'b0;
            #2;
            check("rst_dv",   {31'd0, dv},   32'd0);
            check("rst_byte", {24'd0, rx_byte}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_ferr", {31'd0, ferr}, 32'd0);
            tick(2);
            rst_n = 1'b1;
            tick(8);
         end else begin
            drive_bit(data[i]);
         end
      end
`ifdef UART_RX_PARITY_EN
      drive_bit((^data) ^ par_flip);
`else
      if (par_flip) rx = 1'b1;
`endif
      drive_bit(stop_val);
   endtask

   initial begin
      int k;
      int acc0;
      int ovr0;

      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b1;
      tick(3);
      check("reset_dv",   {31'd0, dv},      32'd0);
      check("reset_byte", {24'd0, rx_byte}, 32'd0);
      check("reset_busy", {31'd0, busy},    32'd0);
      check("reset_ferr", {31'd0, ferr},    32'd0);
      check("reset_perr", {31'd0, perr},    32'd0);
      check("reset_ovr",  {31'd0, ovr},     32'd0);
      rst_n = 1'b1;
      tick(5);

      // clean 8N1 frame, consumer always ready
      acc0 = acc_cnt;
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      tick(20);
      check("a5_count", acc_cnt - acc0,        32'd1);
      check("a5_byte",  {24'd0, last_byte},    32'hA5);
      check("a5_ferr",  {31'd0, last_ferr},    32'd0);
      check("a5_perr",  {31'd0, last_perr},    32'd0);
      check("a5_dv_low", {31'd0, dv},          32'd0);
      check("a5_idle",  {31'd0, busy},         32'd0);

      // 5-cycle low glitch
      acc0 = acc_cnt;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      check("glitch_busy", {31'd0, busy}, 32'd1);
      k = 0;
      while (busy && k < 10) begin
         tick(1);
         k++;
      end
      check("glitch_busy_clear", {31'd0, busy}, 32'd0);
      tick(30);
      check("glitch_no_dv", acc_cnt - acc0, 32'd0);

      // stop bit low, then line held low: frame error and BREAK
      acc0 = acc_cnt;
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      tick(40);
      check("ferr_count", acc_cnt - acc0,     32'd1);
      check("ferr_byte",  {24'd0, last_byte}, 32'h3C);
      check("ferr_flag",  {31'd0, last_ferr}, 32'd1);
      check("break_hold", {31'd0, busy},      32'd1);
      rx = 1'b1;
      k = 0;
      while (busy && k < 6) begin
         tick(1);
         k++;
      end
      check("break_exit", {31'd0, busy}, 32'd0);
      tick(10);

      // two frames with no consumer: overrun
      acc0  = acc_cnt;
      ovr0  = ovr_cnt;
      ready = 1'b0;
      send_frame(8'h11, 1'b1, -1, 1'b0);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      tick(20);
      check("ovr_dv",    {31'd0, dv},      32'd1);
      check("ovr_byte",  {24'd0, rx_byte}, 32'h11);
      check("ovr_pulse", ovr_cnt - ovr0,   32'd1);
      ready = 1'b1;
      tick(1);
      check("ovr_accept_dv", {31'd0, dv},         32'd0);
      check("ovr_accept_n",  acc_cnt - acc0,      32'd1);
      check("ovr_accept_b",  {24'd0, last_byte},  32'h11);
      tick(10);

      // reset during data bit 4; upper bits and stop are high so no new start
      acc0 = acc_cnt;
      send_frame(8'hF1, 1'b1, 4, 1'b0);
      tick(30);
      check("rst_no_dv",  acc_cnt - acc0, 32'd0);
      check("rst_dv_low", {31'd0, dv},    32'd0);
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      tick(20);
      check("post_rst_count", acc_cnt - acc0,     32'd1);
      check("post_rst_byte",  {24'd0, last_byte}, 32'h5A);
      check("post_rst_ferr",  {31'd0, last_ferr}, 32'd0);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, -1, 1'b1);
      tick(20);
      check("par_bad",  {31'd0, last_perr}, 32'd1);
      check("par_bad_byte", {24'd0, last_byte}, 32'h07);
      send_frame(8'h07, 1'b1, -1, 1'b0);
      tick(20);
      check("par_good", {31'd0, last_perr}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
